// File: rtl/usr_pkg.sv
// Shared mode encodings and helpers for the universal shift register.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Modes that move data and advance the shift counter.
    function automatic logic is_shift(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/dff_cell.sv
// Single-bit storage element: sync active-high reset, enable,
// true and complemented outputs.
module dff_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else if (en)
            q <= d;
    end

    assign q_bar = ~q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register built from dff_cell bits,
// with a saturating shift counter and drain status.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             drained,
    output logic             drain_pulse
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        q_nxt = q;
        unique case (mode)
            MODE_HOLD: q_nxt = q;
            MODE_LOAD: q_nxt = d;
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], ser_in_r};
            MODE_SHR:  q_nxt = {ser_in_l, q[WIDTH-1:1]};
            MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_nxt = '0;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .d     (q_nxt[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];

    // Counter saturates at WIDTH; data keeps moving past that point.
    always_comb begin
        cnt_nxt = shift_cnt;
        if (mode == MODE_LOAD || mode == MODE_CLR)
            cnt_nxt = '0;
        else if (is_shift(mode) && shift_cnt != CNT_FULL)
            cnt_nxt = shift_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt   <= '0;
            drained     <= 1'b0;
            drain_pulse <= 1'b0;
        end else if (en) begin
            shift_cnt   <= cnt_nxt;
            drained     <= (cnt_nxt == CNT_FULL);
            drain_pulse <= is_shift(mode) && (shift_cnt == CNT_LAST);
        end else begin
            drain_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg with a behavioural reference
// model checked every cycle plus literal expectations.
module tb_univ_shift_reg;

    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         ser_in_r;
    logic         ser_in_l;
    logic [W-1:0] q;
    logic [W-1:0] q_bar;
    logic         ser_out_l;
    logic         ser_out_r;
    logic [3:0]   shift_cnt;
    logic         drained;
    logic         drain_pulse;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_q;
    int m_cnt;
    int m_drained;
    int m_pulse;
    bit m_valid = 1'b0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .d           (d),
        .ser_in_r    (ser_in_r),
        .ser_in_l    (ser_in_l),
        .q           (q),
        .q_bar       (q_bar),
        .ser_out_l   (ser_out_l),
        .ser_out_r   (ser_out_r),
        .shift_cnt   (shift_cnt),
        .drained     (drained),
        .drain_pulse (drain_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_q = 0;
            m_cnt = 0;
            m_drained = 0;
            m_pulse = 0;
            m_valid = 1'b1;
        end else if (en) begin
            m_pulse = 0;
            case (mode)
                3'd1: m_q = int'(d);
                3'd2: m_q = ((m_q << 1) | int'(ser_in_r)) & MASK;
                3'd3: m_q = (m_q >> 1) | (int'(ser_in_l) << (W - 1));
                3'd4: m_q = ((m_q << 1) | (m_q >> (W - 1))) & MASK;
                3'd5: m_q = (m_q >> 1) | ((m_q & 1) << (W - 1));
                3'd6: m_q = (m_q >> 1) | (m_q & (1 << (W - 1)));
                3'd7: m_q = 0;
                default: ;
            endcase
            if (mode == 3'd1 || mode == 3'd7) begin
                m_cnt = 0;
            end else if (mode >= 3'd2 && mode <= 3'd6) begin
                if (m_cnt == W - 1) m_pulse = 1;
                if (m_cnt < W) m_cnt = m_cnt + 1;
            end
            m_drained = (m_cnt == W) ? 1 : 0;
        end else begin
            m_pulse = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_q", int'(q), m_q);
            check("m_qbar", int'(q_bar), (~m_q) & MASK);
            check("m_sol", int'(ser_out_l), (m_q >> (W - 1)) & 1);
            check("m_sor", int'(ser_out_r), m_q & 1);
            check("m_cnt", int'(shift_cnt), m_cnt);
            check("m_drained", int'(drained), m_drained);
            check("m_pulse", int'(drain_pulse), m_pulse);
        end
    end

    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [W-1:0] dv, input logic sr,
                        input logic sl);
        rst = r;
        en = e;
        mode = m;
        d = dv;
        ser_in_r = sr;
        ser_in_l = sl;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sol_exp;

    initial begin
        rst = 1'b1;
        en = 1'b0;
        mode = 3'd0;
        d = '0;
        ser_in_r = 1'b0;
        ser_in_l = 1'b0;
        sol_exp = 8'b1000_0001;

        step(1, 0, 3'd0, 8'h00, 0, 0);
        step(1, 0, 3'd0, 8'h00, 0, 0);
        step(0, 1, 3'd0, 8'h00, 0, 0);
        check("rst_q", int'(q), 8'h00);
        check("rst_qbar", int'(q_bar), 8'hFF);
        check("rst_cnt", int'(shift_cnt), 0);
        check("rst_drained", int'(drained), 0);

        step(0, 1, 3'd1, 8'hB4, 0, 0);
        check("load_b4", int'(q), 8'hB4);
        step(0, 1, 3'd4, 8'h00, 0, 0);
        check("rol_q", int'(q), 8'h69);
        check("rol_cnt", int'(shift_cnt), 1);
        step(0, 1, 3'd5, 8'h00, 0, 0);
        check("ror_q", int'(q), 8'hB4);
        check("ror_cnt", int'(shift_cnt), 2);

        step(0, 1, 3'd1, 8'h81, 0, 0);
        for (int i = 0; i < 8; i++) begin
            check("shl_sol", int'(ser_out_l), int'(sol_exp[7 - i]));
            step(0, 1, 3'd2, 8'h00, 0, 0);
            check("shl_pulse", int'(drain_pulse), (i == 7) ? 1 : 0);
        end
        check("shl8_q", int'(q), 8'h00);
        check("shl8_cnt", int'(shift_cnt), 8);
        check("shl8_drained", int'(drained), 1);
        step(0, 1, 3'd2, 8'h00, 0, 0);
        check("shl9_cnt", int'(shift_cnt), 8);
        check("shl9_pulse", int'(drain_pulse), 0);
        check("shl9_drained", int'(drained), 1);

        step(0, 1, 3'd1, 8'h90, 0, 0);
        check("load_drained", int'(drained), 0);
        check("load_cnt", int'(shift_cnt), 0);
        step(0, 1, 3'd6, 8'h00, 0, 0);
        check("asr1", int'(q), 8'hC8);
        step(0, 1, 3'd6, 8'h00, 0, 0);
        check("asr2", int'(q), 8'hE4);
        step(0, 1, 3'd3, 8'h00, 0, 0);
        check("shr", int'(q), 8'h72);

        for (int i = 0; i < 3; i++) begin
            step(0, 0, 3'd2, 8'hFF, 1, 1);
            check("en0_q", int'(q), 8'h72);
            check("en0_cnt", int'(shift_cnt), 3);
            check("en0_pulse", int'(drain_pulse), 0);
        end
        step(0, 1, 3'd7, 8'hFF, 0, 0);
        check("clr_q", int'(q), 8'h00);
        check("clr_cnt", int'(shift_cnt), 0);
        check("clr_drained", int'(drained), 0);

        step(0, 1, 3'd1, 8'h5A, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 3'd2, 8'h00, 1, 0);
        check("pre_rst_cnt", int'(shift_cnt), 3);
        check("pre_rst_q", int'(q), 8'hD7);
        step(1, 1, 3'd2, 8'h00, 1, 0);
        check("midrst_q", int'(q), 8'h00);
        check("midrst_cnt", int'(shift_cnt), 0);
        check("midrst_drained", int'(drained), 0);
        step(0, 1, 3'd0, 8'h00, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
